// File: rtl/lsu_mem_bridge.sv
// lsu_mem_bridge: turns one CPU byte/half/word access into a strobed word bus transaction and returns the extended result
module lsu_mem_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_wen,
  input  logic [2:0]  req_memop,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_wen,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t state, state_n;
  logic        wen_q, err_q, err_n, illegal, expired, done, act;
  logic [2:0]  memop_q;
  logic [7:0]  cnt;
  logic [31:0] addr_q, wdata_q, rdata_q, rdata_n, shifted, load_data;

  assign illegal = (req_wen ? req_memop[2] || req_memop[1:0] == 2'b11
                            : req_memop[1:0] == 2'b11 || req_memop[2:1] == 2'b11)
                || (req_memop[1:0] == 2'b01 && req_addr[0])
                || (req_memop[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
  assign expired = cnt >= 8'(TIMEOUT - 1);
  assign done = state == REQ ? bus_ready && bus_rvalid : bus_rvalid;
  assign shifted = bus_rdata >> {addr_q[1:0], 3'b000};
  assign load_data = wen_q ? '0
                   : memop_q[1:0] == 2'b00 ? {{24{shifted[7] & ~memop_q[2]}}, shifted[7:0]}
                   : memop_q[1:0] == 2'b01 ? {{16{shifted[15] & ~memop_q[2]}}, shifted[15:0]}
                   : shifted;

  assign act = state == REQ && !rst;
  assign req_ready = state == IDLE && !rst;
  assign resp_valid = state == RESP && !rst;
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_err = resp_valid & err_q;
  assign bus_valid = act;
  assign bus_wen = act & wen_q;
  assign bus_addr = act ? {addr_q[31:2], 2'b00} : '0;
  assign bus_wdata = !(act && wen_q) ? '0
                   : memop_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}}
                   : memop_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}}
                   : wdata_q;
  assign bus_wstrb = !(act && wen_q) ? 4'b0000
                   : memop_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0]
                   : memop_q[1:0] == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011)
                   : 4'b1111;

  always_comb begin
    state_n = state;
    rdata_n = '0;
    err_n = 1'b0;
    case (state)
      IDLE: begin
        state_n = req_valid ? (illegal ? RESP : REQ) : IDLE;
        err_n = req_valid && illegal;
      end
      REQ, WAIT: begin
        // a completing bus handshake wins over an expiring timeout in the same cycle
        state_n = done || expired ? RESP : state == REQ && bus_ready ? WAIT : state;
        rdata_n = done ? load_data : '0;
        err_n = !done && expired;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      wen_q <= 1'b0;
      memop_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_n;
      rdata_q <= rdata_n;
      err_q <= err_n;
      if (state == IDLE && req_valid) begin
        wen_q <= req_wen;
        memop_q <= req_memop;
        addr_q <= req_addr;
        wdata_q <= req_wdata;
        cnt <= '0;
      end else if (state == REQ || state == WAIT) begin
        cnt <= cnt + 8'd1;
      end
    end
  end
endmodule

// File: doc/lsu_mem_bridge.md
Name: lsu_mem_bridge

Overview:
- Load/store bridge directly downstream of riscv_cpu's data-memory port (memop, memdata, mem_wen, mem_addr, mem_data).
- Converts one byte/half/word access into a word-aligned, byte-strobed bus transaction with valid/ready request and rvalid response.
- Returns the load result sign- or zero-extended, or a write acknowledge.
- Flags misaligned accesses, illegal memops and bus timeouts as errors; the CPU stalls while req_ready is low.

Parameters:
TIMEOUT, 255, max cycles spent in REQ+WAIT before the access is aborted with error (counter width 8)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  CPU access request
req_wen  in  1  1 = store, 0 = load
req_memop  in  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
req_ready  out  1  bridge idle, accepts request
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores/errors
resp_err  out  1  qualifies resp_valid: misaligned/illegal/timeout
bus_valid  out  1  bus request valid
bus_ready  in  1  bus accepts request
bus_wen  out  1  bus write
bus_addr  out  32  {req_addr[31:2],2'b00}
bus_wdata  out  32  lane-replicated store data
bus_wstrb  out  4  byte strobes (0000 on reads)
bus_rvalid  in  1  read data / write ack
bus_rdata  in  32  raw read word

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high. Under rst: state IDLE, all outputs 0, timeout counter 0. req_ready = (state==IDLE) && !rst.
- States: IDLE, REQ, WAIT, RESP.
- IDLE: on req_valid, latch wen/memop/addr/wdata.
  - If illegal, go to RESP with err, no bus traffic.
  - Otherwise go to REQ.
  - Illegal cases:
    - load memop in {011,110,111}
    - store memop not in {000,001,010}
    - H/HU with addr[0]=1
    - W with addr[1:0]!=0
- REQ: bus_valid=1; address, data and strobes held stable until bus_ready.
  - bus_ready && bus_rvalid in the same cycle: go to RESP with the data.
  - bus_ready alone: go to WAIT.
- WAIT: bus_valid=0. On bus_rvalid, capture bus_rdata and go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. A new request is accepted at the earliest on the cycle after RESP; minimum latency from accept to resp_valid is 2 cycles.
- Timeout: counter cleared on accept and incremented each cycle in REQ/WAIT. When it reaches TIMEOUT: go to RESP with err=1, rdata=0, bus_valid dropped. A late bus_rvalid after that is ignored.
- bus_rvalid in IDLE/RESP is ignored.
- Store lanes:
  - SB: wdata={4{b}}, wstrb=0001<<addr[1:0].
  - SH: wdata={2{h}}, wstrb=0011 (addr[1]=0) or 1100.
  - SW: wdata=req_wdata, wstrb=1111.
- Load path: shifted = bus_rdata >> (8*addr[1:0]).
  - LB/LBU: sign/zero-extend shifted[7:0].
  - LH/LHU: sign/zero-extend shifted[15:0].
  - LW: shifted.
- resp_rdata is registered and valid only with resp_valid; it is 0 otherwise, and 0 for stores.
- Reset mid-operation aborts the access: no response, back to IDLE.

Test Plan:
- LB addr 0x80000003, bus_rdata 0x80FF1234 returned one cycle after accept with immediate ready -> resp_rdata 0xFFFFFF80, err 0. LBU of the same access -> 0x00000080.
- SH addr 0x80000002, wdata 0x0000BEEF -> bus_addr 0x80000000, bus_wdata 0xBEEFBEEF, wstrb 1100, bus_wen 1. After rvalid: resp_valid with rdata 0.
- LW addr 0x80000001 -> resp_valid on the cycle after accept, err 1, bus_valid never asserted. Load memop 011 -> same result.
- bus_ready held low 3 cycles -> bus_valid and bus_addr stable throughout. Then rvalid 2 cycles later: LHU at offset 2 of 0xA5A5C3C3 -> 0x0000A5A5.
- TIMEOUT=4, bus never readies -> resp_err after 4 cycles in REQ, bus_valid drops; a later rvalid produces no second response.
- rst asserted while in WAIT -> no resp_valid, next cycle req_ready=1. A fresh SW then completes normally.
